// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Moore sequencer for the 8-bit CPU data path. It fetches an
//               opcode into IR and decodes it. Conditional branches sample
//               CCR_Result in the decode state. It then steps through the
//               execute states. Every strobe and select is a pure function
//               of the current state.
// Ports       : clk         - rising-edge clock
//               reset       - asynchronous, active-low
//               IR          - current opcode held by the data path
//               CCR_Result  - flags {N,Z,V,C}
//               IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load,
//               CCR_Load    - register load / increment strobes
//               ALU_Sel     - ALU operation select
//               Bus1_Sel    - 00 PC, 01 A, 10 B
//               Bus2_Sel    - 00 ALU, 01 BUS1, 10 memory
//               write       - memory write of BUS1 at MAR
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit #(
    parameter int ILLEGAL_AS_NOP = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] IR,
    input  logic [3:0] CCR_Result,
    output logic       IR_Load,
    output logic       MAR_Load,
    output logic       PC_Load,
    output logic       PC_Inc,
    output logic       A_Load,
    output logic       B_Load,
    output logic [2:0] ALU_Sel,
    output logic       CCR_Load,
    output logic [1:0] Bus1_Sel,
    output logic [1:0] Bus2_Sel,
    output logic       write
);

    // Opcodes
    localparam logic [7:0] c_LDA_IMM = 8'h86;
    localparam logic [7:0] c_LDA_DIR = 8'h87;
    localparam logic [7:0] c_LDB_IMM = 8'h88;
    localparam logic [7:0] c_LDB_DIR = 8'h89;
    localparam logic [7:0] c_STA_DIR = 8'h96;
    localparam logic [7:0] c_STB_DIR = 8'h97;
    localparam logic [7:0] c_ADD_AB  = 8'h42;
    localparam logic [7:0] c_SUB_AB  = 8'h43;
    localparam logic [7:0] c_AND_AB  = 8'h44;
    localparam logic [7:0] c_OR_AB   = 8'h45;
    localparam logic [7:0] c_INCA    = 8'h46;
    localparam logic [7:0] c_INCB    = 8'h47;
    localparam logic [7:0] c_DECA    = 8'h48;
    localparam logic [7:0] c_DECB    = 8'h49;
    localparam logic [7:0] c_BRA     = 8'h20;
    localparam logic [7:0] c_BMI     = 8'h21;
    localparam logic [7:0] c_BPL     = 8'h22;
    localparam logic [7:0] c_BEQ     = 8'h23;
    localparam logic [7:0] c_BNE     = 8'h24;
    localparam logic [7:0] c_BVS     = 8'h25;
    localparam logic [7:0] c_BVC     = 8'h26;
    localparam logic [7:0] c_BCS     = 8'h27;
    localparam logic [7:0] c_BCC     = 8'h28;

    // Bus and ALU selects
    localparam logic [1:0] c_BUS1_PC   = 2'b00;
    localparam logic [1:0] c_BUS1_A    = 2'b01;
    localparam logic [1:0] c_BUS1_B    = 2'b10;
    localparam logic [1:0] c_BUS2_ALU  = 2'b00;
    localparam logic [1:0] c_BUS2_BUS1 = 2'b01;
    localparam logic [1:0] c_BUS2_MEM  = 2'b10;
    localparam logic [2:0] c_ALU_ADD   = 3'b000;
    localparam logic [2:0] c_ALU_SUB   = 3'b001;
    localparam logic [2:0] c_ALU_AND   = 3'b010;
    localparam logic [2:0] c_ALU_OR    = 3'b011;
    localparam logic [2:0] c_ALU_INC   = 3'b100;
    localparam logic [2:0] c_ALU_DEC   = 3'b101;

    // The operand fetch (OP_4/OP_5) and the direct-address states are shared
    // between instructions. IR is stable after FETCH_2, so the shared states
    // pick their successor from IR. The outputs never look at IR.
    typedef enum logic [4:0] {
        S_FETCH_0   = 5'd0,
        S_FETCH_1   = 5'd1,
        S_FETCH_2   = 5'd2,
        S_DECODE_3  = 5'd3,
        S_OP_4      = 5'd4,
        S_OP_5      = 5'd5,
        S_BRA_5     = 5'd6,
        S_LDA_IMM_6 = 5'd7,
        S_LDB_IMM_6 = 5'd8,
        S_DIR_6     = 5'd9,
        S_BRA_6     = 5'd10,
        S_LD_DIR_7  = 5'd11,
        S_STA_7     = 5'd12,
        S_STB_7     = 5'd13,
        S_LDA_DIR_8 = 5'd14,
        S_LDB_DIR_8 = 5'd15,
        S_ADD_4     = 5'd16,
        S_SUB_4     = 5'd17,
        S_AND_4     = 5'd18,
        S_OR_4      = 5'd19,
        S_INCA_4    = 5'd20,
        S_INCB_4    = 5'd21,
        S_DECA_4    = 5'd22,
        S_DECB_4    = 5'd23,
        S_BNT_4     = 5'd24,
        S_HALT      = 5'd25
    } state_t;

    state_t r_state_q;
    state_t w_state_d;
    logic   w_is_branch;
    logic   w_cond_met;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_q <= S_FETCH_0;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        IR_Load   = 1'b0;
        MAR_Load  = 1'b0;
        PC_Load   = 1'b0;
        PC_Inc    = 1'b0;
        A_Load    = 1'b0;
        B_Load    = 1'b0;
        ALU_Sel   = c_ALU_ADD;
        CCR_Load  = 1'b0;
        Bus1_Sel  = c_BUS1_PC;
        Bus2_Sel  = c_BUS2_ALU;
        write     = 1'b0;

        w_is_branch = (IR >= c_BRA) && (IR <= c_BCC);

        // Branch condition on {N,Z,V,C}; used only in the decode state.
        w_cond_met = 1'b0;
        case (IR)
            c_BMI:   w_cond_met =  CCR_Result[3];
            c_BPL:   w_cond_met = ~CCR_Result[3];
            c_BEQ:   w_cond_met =  CCR_Result[2];
            c_BNE:   w_cond_met = ~CCR_Result[2];
            c_BVS:   w_cond_met =  CCR_Result[1];
            c_BVC:   w_cond_met = ~CCR_Result[1];
            c_BCS:   w_cond_met =  CCR_Result[0];
            c_BCC:   w_cond_met = ~CCR_Result[0];
            default: w_cond_met = 1'b0;
        endcase

        case (r_state_q)
            S_FETCH_0: begin
                Bus1_Sel  = c_BUS1_PC;
                Bus2_Sel  = c_BUS2_BUS1;
                MAR_Load  = 1'b1;
                w_state_d = S_FETCH_1;
            end
            S_FETCH_1: begin
                PC_Inc    = 1'b1;
                w_state_d = S_FETCH_2;
            end
            S_FETCH_2: begin
                Bus2_Sel  = c_BUS2_MEM;
                IR_Load   = 1'b1;
                w_state_d = S_DECODE_3;
            end
            S_DECODE_3: begin
                case (IR)
                    c_LDA_IMM, c_LDB_IMM, c_LDA_DIR, c_LDB_DIR,
                    c_STA_DIR, c_STB_DIR, c_BRA:   w_state_d = S_OP_4;
                    c_ADD_AB:                      w_state_d = S_ADD_4;
                    c_SUB_AB:                      w_state_d = S_SUB_4;
                    c_AND_AB:                      w_state_d = S_AND_4;
                    c_OR_AB:                       w_state_d = S_OR_4;
                    c_INCA:                        w_state_d = S_INCA_4;
                    c_INCB:                        w_state_d = S_INCB_4;
                    c_DECA:                        w_state_d = S_DECA_4;
                    c_DECB:                        w_state_d = S_DECB_4;
                    c_BMI, c_BPL, c_BEQ, c_BNE,
                    c_BVS, c_BVC, c_BCS, c_BCC:
                        w_state_d = w_cond_met ? S_OP_4 : S_BNT_4;
                    default:
                        w_state_d = (ILLEGAL_AS_NOP != 0) ? S_FETCH_0 : S_HALT;
                endcase
            end
            S_OP_4: begin
                Bus1_Sel  = c_BUS1_PC;
                Bus2_Sel  = c_BUS2_BUS1;
                MAR_Load  = 1'b1;
                // A taken branch keeps PC on the operand; it gets overwritten.
                w_state_d = w_is_branch ? S_BRA_5 : S_OP_5;
            end
            S_OP_5: begin
                PC_Inc = 1'b1;
                case (IR)
                    c_LDA_IMM:                                 w_state_d = S_LDA_IMM_6;
                    c_LDB_IMM:                                 w_state_d = S_LDB_IMM_6;
                    c_LDA_DIR, c_LDB_DIR, c_STA_DIR, c_STB_DIR: w_state_d = S_DIR_6;
                    default:                                   w_state_d = S_FETCH_0;
                endcase
            end
            S_BRA_5: begin
                w_state_d = S_BRA_6;
            end
            S_LDA_IMM_6: begin
                Bus2_Sel  = c_BUS2_MEM;
                A_Load    = 1'b1;
                w_state_d = S_FETCH_0;
            end
            S_LDB_IMM_6: begin
                Bus2_Sel  = c_BUS2_MEM;
                B_Load    = 1'b1;
                w_state_d = S_FETCH_0;
            end
            S_DIR_6: begin
                // The operand byte becomes the new memory address.
                Bus2_Sel = c_BUS2_MEM;
                MAR_Load = 1'b1;
                case (IR)
                    c_STA_DIR:            w_state_d = S_STA_7;
                    c_STB_DIR:            w_state_d = S_STB_7;
                    c_LDA_DIR, c_LDB_DIR: w_state_d = S_LD_DIR_7;
                    default:              w_state_d = S_FETCH_0;
                endcase
            end
            S_BRA_6: begin
                Bus2_Sel  = c_BUS2_MEM;
                PC_Load   = 1'b1;
                w_state_d = S_FETCH_0;
            end
            S_LD_DIR_7: begin
                // Memory data for the new MAR is valid one cycle later.
                case (IR)
                    c_LDA_DIR: w_state_d = S_LDA_DIR_8;
                    c_LDB_DIR: w_state_d = S_LDB_DIR_8;
                    default:   w_state_d = S_FETCH_0;
                endcase
            end
            S_STA_7: begin
                Bus1_Sel  = c_BUS1_A;
                write     = 1'b1;
                w_state_d = S_FETCH_0;
            end
            S_STB_7: begin
                Bus1_Sel  = c_BUS1_B;
                write     = 1'b1;
                w_state_d = S_FETCH_0;
            end
            S_LDA_DIR_8: begin
                Bus2_Sel  = c_BUS2_MEM;
                A_Load    = 1'b1;
                w_state_d = S_FETCH_0;
            end
            S_LDB_DIR_8: begin
                Bus2_Sel  = c_BUS2_MEM;
                B_Load    = 1'b1;
                w_state_d = S_FETCH_0;
            end
            S_ADD_4, S_SUB_4, S_AND_4, S_OR_4: begin
                Bus1_Sel = c_BUS1_A;
                Bus2_Sel = c_BUS2_ALU;
                A_Load   = 1'b1;
                CCR_Load = 1'b1;
                case (r_state_q)
                    S_SUB_4: ALU_Sel = c_ALU_SUB;
                    S_AND_4: ALU_Sel = c_ALU_AND;
                    S_OR_4:  ALU_Sel = c_ALU_OR;
                    default: ALU_Sel = c_ALU_ADD;
                endcase
                w_state_d = S_FETCH_0;
            end
            S_INCA_4, S_DECA_4: begin
                Bus1_Sel  = c_BUS1_A;
                Bus2_Sel  = c_BUS2_ALU;
                ALU_Sel   = (r_state_q == S_INCA_4) ? c_ALU_INC : c_ALU_DEC;
                A_Load    = 1'b1;
                CCR_Load  = 1'b1;
                w_state_d = S_FETCH_0;
            end
            S_INCB_4, S_DECB_4: begin
                Bus1_Sel  = c_BUS1_B;
                Bus2_Sel  = c_BUS2_ALU;
                ALU_Sel   = (r_state_q == S_INCB_4) ? c_ALU_INC : c_ALU_DEC;
                B_Load    = 1'b1;
                CCR_Load  = 1'b1;
                w_state_d = S_FETCH_0;
            end
            S_BNT_4: begin
                // Branch not taken: step PC over the unused operand byte.
                PC_Inc    = 1'b1;
                w_state_d = S_FETCH_0;
            end
            S_HALT: begin
                w_state_d = S_HALT;
            end
            default: begin
                w_state_d = S_FETCH_0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_unit
// Description : Bench for control_unit. A small data path model (PC, MAR,
//               A, B, CCR, IR, memory) follows the DUT strobes and feeds IR
//               and the flags back to the DUT. An instruction-level model
//               predicts the strobe vector for every cycle and the final
//               register contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // Strobe vector layout:
    // [14]IR_Load [13]MAR_Load [12]PC_Load [11]PC_Inc [10]A_Load [9]B_Load
    // [8:6]ALU_Sel [5]CCR_Load [4:3]Bus1_Sel [2:1]Bus2_Sel [0]write
    localparam logic [14:0] E_F0   = 15'b0_1_0_0_0_0_000_0_00_01_0;
    localparam logic [14:0] E_PCI  = 15'b0_0_0_1_0_0_000_0_00_00_0;
    localparam logic [14:0] E_IRL  = 15'b1_0_0_0_0_0_000_0_00_10_0;
    localparam logic [14:0] E_NONE = 15'b0;
    localparam logic [14:0] E_MMAR = 15'b0_1_0_0_0_0_000_0_00_10_0;
    localparam logic [14:0] E_LDA  = 15'b0_0_0_0_1_0_000_0_00_10_0;
    localparam logic [14:0] E_LDB  = 15'b0_0_0_0_0_1_000_0_00_10_0;
    localparam logic [14:0] E_PCL  = 15'b0_0_1_0_0_0_000_0_00_10_0;
    localparam logic [14:0] E_STA  = 15'b0_0_0_0_0_0_000_0_01_00_1;
    localparam logic [14:0] E_STB  = 15'b0_0_0_0_0_0_000_0_10_00_1;

    // Main DUT outputs
    logic       ir_load, mar_load, pc_load, pc_inc, a_load, b_load, ccr_load, wr;
    logic [2:0] alu_sel;
    logic [1:0] bus1_sel, bus2_sel;
    logic [14:0] out_v;
    assign out_v = {ir_load, mar_load, pc_load, pc_inc, a_load, b_load,
                    alu_sel, ccr_load, bus1_sel, bus2_sel, wr};

    // Halting-variant DUT outputs
    logic       h_ir_load, h_mar_load, h_pc_load, h_pc_inc, h_a_load, h_b_load, h_ccr_load, h_wr;
    logic [2:0] h_alu_sel;
    logic [1:0] h_bus1_sel, h_bus2_sel;
    logic [14:0] h_v;
    assign h_v = {h_ir_load, h_mar_load, h_pc_load, h_pc_inc, h_a_load, h_b_load,
                  h_alu_sel, h_ccr_load, h_bus1_sel, h_bus2_sel, h_wr};

    // Data path model state
    logic [7:0] dp_pc, dp_mar, dp_a, dp_b, dp_ir;
    logic [3:0] dp_ccr;
    logic [7:0] dp_mem [256];
    logic [7:0] prog   [256];
    logic [7:0] bus1, bus2;
    logic [11:0] alu_o;

    control_unit #(.ILLEGAL_AS_NOP(1)) dut (
        .clk(clk), .reset(reset), .IR(dp_ir), .CCR_Result(dp_ccr),
        .IR_Load(ir_load), .MAR_Load(mar_load), .PC_Load(pc_load), .PC_Inc(pc_inc),
        .A_Load(a_load), .B_Load(b_load), .ALU_Sel(alu_sel), .CCR_Load(ccr_load),
        .Bus1_Sel(bus1_sel), .Bus2_Sel(bus2_sel), .write(wr)
    );

    control_unit #(.ILLEGAL_AS_NOP(0)) dut_halt (
        .clk(clk), .reset(reset), .IR(8'hFF), .CCR_Result(4'h0),
        .IR_Load(h_ir_load), .MAR_Load(h_mar_load), .PC_Load(h_pc_load), .PC_Inc(h_pc_inc),
        .A_Load(h_a_load), .B_Load(h_b_load), .ALU_Sel(h_alu_sel), .CCR_Load(h_ccr_load),
        .Bus1_Sel(h_bus1_sel), .Bus2_Sel(h_bus2_sel), .write(h_wr)
    );

    // ALU of the CPU: returns {N,Z,V,C,result}
    function automatic logic [11:0] alu(input logic [2:0] sel, input logic [7:0] x, input logic [7:0] y);
        logic [8:0] r;
        logic v, c;
        r = 9'd0; v = 1'b0; c = 1'b0;
        case (sel)
            3'd0: begin r = {1'b0, y} + {1'b0, x}; c = r[8]; v = (x[7] == y[7]) && (r[7] != x[7]); end
            3'd1: begin r = {1'b0, x - y}; c = (x < y); v = (x[7] != y[7]) && (r[7] != x[7]); end
            3'd2: r = {1'b0, x & y};
            3'd3: r = {1'b0, x | y};
            3'd4: begin r = {1'b0, x + 8'd1}; c = (x == 8'hFF); v = (x == 8'h7F); end
            3'd5: begin r = {1'b0, x - 8'd1}; c = (x == 8'h00); v = (x == 8'h80); end
            default: r = 9'd0;
        endcase
        return {r[7], (r[7:0] == 8'd0), v, c, r[7:0]};
    endfunction

    always_comb begin
        bus1 = 8'd0;
        case (bus1_sel)
            2'b00: bus1 = dp_pc;
            2'b01: bus1 = dp_a;
            2'b10: bus1 = dp_b;
            default: bus1 = 8'd0;
        endcase
        alu_o = alu(alu_sel, bus1, dp_b);
        bus2 = 8'd0;
        case (bus2_sel)
            2'b00: bus2 = alu_o[7:0];
            2'b01: bus2 = bus1;
            2'b10: bus2 = dp_mem[dp_mar];
            default: bus2 = 8'd0;
        endcase
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            dp_pc <= 8'd0; dp_mar <= 8'd0; dp_a <= 8'd0; dp_b <= 8'd0;
            dp_ir <= 8'd0; dp_ccr <= 4'd0;
            for (int i = 0; i < 256; i++) dp_mem[i] <= prog[i];
        end else begin
            if (ir_load)  dp_ir  <= bus2;
            if (mar_load) dp_mar <= bus2;
            if (pc_load)       dp_pc <= bus2;
            else if (pc_inc)   dp_pc <= dp_pc + 8'd1;
            if (a_load)   dp_a   <= bus2;
            if (b_load)   dp_b   <= bus2;
            if (ccr_load) dp_ccr <= alu_o[11:8];
            if (wr)       dp_mem[dp_mar] <= bus1;
        end
    end

    // Checking infrastructure
    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    logic chk_en = 1'b0;
    logic [14:0] exp_q [$];
    logic [14:0] cmp_e;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && exp_q.size() != 0) begin
            cmp_e = exp_q.pop_front();
            check($sformatf("strobes cycle %0d", cyc), 32'(out_v), 32'(cmp_e));
            cyc++;
        end
    end

    // Instruction-level model
    logic [7:0] m_mem [256];
    logic [7:0] m_pc, m_a, m_b;
    logic [3:0] m_ccr;

    task automatic predict(input int n);
        logic [7:0] op, opd, x;
        logic [11:0] r;
        logic [2:0] sel;
        logic flag, taken;
        int idx;
        for (int i = 0; i < 256; i++) m_mem[i] = prog[i];
        m_pc = 8'd0; m_a = 8'd0; m_b = 8'd0; m_ccr = 4'd0;
        exp_q.delete();
        cyc = 0;
        for (int k = 0; k < n; k++) begin
            op  = m_mem[m_pc];
            opd = m_mem[m_pc + 8'd1];
            exp_q.push_back(E_F0); exp_q.push_back(E_PCI);
            exp_q.push_back(E_IRL); exp_q.push_back(E_NONE);
            if (op == 8'h86 || op == 8'h88) begin
                exp_q.push_back(E_F0); exp_q.push_back(E_PCI);
                exp_q.push_back(op == 8'h86 ? E_LDA : E_LDB);
                if (op == 8'h86) m_a = opd; else m_b = opd;
                m_pc = m_pc + 8'd2;
            end else if (op == 8'h87 || op == 8'h89) begin
                exp_q.push_back(E_F0); exp_q.push_back(E_PCI);
                exp_q.push_back(E_MMAR); exp_q.push_back(E_NONE);
                exp_q.push_back(op == 8'h87 ? E_LDA : E_LDB);
                if (op == 8'h87) m_a = m_mem[opd]; else m_b = m_mem[opd];
                m_pc = m_pc + 8'd2;
            end else if (op == 8'h96 || op == 8'h97) begin
                exp_q.push_back(E_F0); exp_q.push_back(E_PCI);
                exp_q.push_back(E_MMAR);
                exp_q.push_back(op == 8'h96 ? E_STA : E_STB);
                m_mem[opd] = (op == 8'h96) ? m_a : m_b;
                m_pc = m_pc + 8'd2;
            end else if (op >= 8'h42 && op <= 8'h45) begin
                sel = 3'(op - 8'h42);
                r = alu(sel, m_a, m_b);
                exp_q.push_back({6'b000010, sel, 1'b1, 2'b01, 2'b00, 1'b0});
                m_a = r[7:0]; m_ccr = r[11:8];
                m_pc = m_pc + 8'd1;
            end else if (op >= 8'h46 && op <= 8'h49) begin
                sel = (op < 8'h48) ? 3'd4 : 3'd5;
                x = (op == 8'h46 || op == 8'h48) ? m_a : m_b;
                r = alu(sel, x, m_b);
                if (op == 8'h46 || op == 8'h48) begin
                    exp_q.push_back({6'b000010, sel, 1'b1, 2'b01, 2'b00, 1'b0});
                    m_a = r[7:0];
                end else begin
                    exp_q.push_back({6'b000001, sel, 1'b1, 2'b10, 2'b00, 1'b0});
                    m_b = r[7:0];
                end
                m_ccr = r[11:8];
                m_pc = m_pc + 8'd1;
            end else if (op >= 8'h20 && op <= 8'h28) begin
                taken = 1'b1;
                if (op != 8'h20) begin
                    idx = int'(op) - 8'h21;
                    flag = m_ccr[3 - idx / 2];
                    taken = (idx % 2 == 0) ? flag : !flag;
                end
                if (taken) begin
                    exp_q.push_back(E_F0); exp_q.push_back(E_NONE); exp_q.push_back(E_PCL);
                    m_pc = opd;
                end else begin
                    exp_q.push_back(E_PCI);
                    m_pc = m_pc + 8'd2;
                end
            end else begin
                m_pc = m_pc + 8'd1;
            end
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    endtask

    task automatic load(input int base, input logic [7:0] b[$]);
        for (int i = 0; i < b.size(); i++) prog[(base + i) % 256] = b[i];
    endtask

    task automatic run_prog(input string nm, input int n);
        int cnt;
        reset = 1'b0;
        @(posedge clk); #1;
        predict(n);
        reset = 1'b1;
        chk_en = 1'b1;
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 500) begin
            @(posedge clk);
            cnt++;
        end
        chk_en = 1'b0;
        if (exp_q.size() != 0) begin
            n_checks++; n_err++;
            $display("FAIL %s timeout: %0d cycles left, required 0", nm, exp_q.size());
            exp_q.delete();
        end
        #1;
        check({nm, " A"},   32'(dp_a),   32'(m_a));
        check({nm, " B"},   32'(dp_b),   32'(m_b));
        check({nm, " PC"},  32'(dp_pc),  32'(m_pc));
        check({nm, " CCR"}, 32'(dp_ccr), 32'(m_ccr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        clear_prog();
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", 32'(out_v), 32'(E_F0));
        check("reset outputs halt variant", 32'(h_v), 32'(E_F0));

        // Reset in the wait state of LDA_DIR
        clear_prog();
        load(0, '{8'h87, 8'hE0});
        prog[8'hE0] = 8'h77;
        @(posedge clk); #1;
        predict(1);
        void'(exp_q.pop_back());
        reset = 1'b1;
        chk_en = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk); #1;
        chk_en = 1'b0;
        exp_q.delete();
        check("O7 wait outputs", 32'(out_v), 32'(E_NONE));
        reset = 1'b0;
        #1;
        check("async reset mid-instruction", 32'(out_v), 32'(E_F0));
        check("no write in reset", 32'(wr), 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        check("F0 after release", 32'(out_v), 32'(15'b0_1_0_0_0_0_000_0_00_01_0));
        @(posedge clk); #1;
        check("F1 after release", 32'(out_v), 32'(E_PCI));

        // Immediate loads and ADD
        clear_prog();
        load(0, '{8'h86, 8'h12, 8'h88, 8'h30, 8'h42});
        run_prog("ldimm_add", 3);
        check("ldimm_add A lit", 32'(dp_a), 32'h42);
        check("ldimm_add CCR lit", 32'(dp_ccr), 32'h0);
        check("ldimm_add PC lit", 32'(dp_pc), 32'h05);

        // Signed overflow then BMI taken
        clear_prog();
        load(0, '{8'h86, 8'h7F, 8'h88, 8'h01, 8'h42, 8'h21, 8'h40});
        run_prog("ovf_bmi", 4);
        check("ovf_bmi A lit", 32'(dp_a), 32'h80);
        check("ovf_bmi CCR lit", 32'(dp_ccr), 32'hA);
        check("ovf_bmi PC lit", 32'(dp_pc), 32'h40);

        // Branch mix: BEQ not taken at 10h, BNE/BCC taken, BCS not taken
        clear_prog();
        load(8'h00, '{8'h86, 8'h01, 8'h88, 8'h01, 8'h42, 8'h20, 8'h10});
        load(8'h10, '{8'h23, 8'h40, 8'h24, 8'h20});
        load(8'h20, '{8'h49, 8'h28, 8'h30});
        load(8'h30, '{8'h27, 8'h00});
        run_prog("branches", 9);
        check("branches PC lit", 32'(dp_pc), 32'h32);
        check("branches B lit", 32'(dp_b), 32'h00);
        check("branches CCR lit", 32'(dp_ccr), 32'h4);

        // Stores, direct loads and an illegal opcode as NOP
        clear_prog();
        load(0, '{8'h86, 8'h5A, 8'h96, 8'hE0, 8'h88, 8'hA5, 8'h97, 8'hE1,
                  8'h87, 8'hE1, 8'hFF, 8'h89, 8'hE0});
        run_prog("store_load", 7);
        check("store mem E0 lit", 32'(dp_mem[8'hE0]), 32'h5A);
        check("store mem E1 lit", 32'(dp_mem[8'hE1]), 32'hA5);
        check("store_load MAR lit", 32'(dp_mar), 32'hE0);
        check("store_load PC lit", 32'(dp_pc), 32'h0D);

        // Remaining ALU ops and the other branch conditions
        clear_prog();
        load(8'h00, '{8'h86, 8'hF0, 8'h88, 8'h0F, 8'h45, 8'h44, 8'h43,
                      8'h48, 8'h46, 8'h47, 8'h22, 8'h50});
        load(8'h50, '{8'h25, 8'h00, 8'h26, 8'h60});
        load(8'h60, '{8'h21, 8'h00});
        run_prog("alu_mix", 12);
        check("alu_mix A lit", 32'(dp_a), 32'h00);
        check("alu_mix B lit", 32'(dp_b), 32'h10);
        check("alu_mix PC lit", 32'(dp_pc), 32'h62);

        // Halting variant: opcode FFh parks the unit with all outputs low
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            case (i)
                0:       check("halt F0", 32'(h_v), 32'(E_F0));
                1:       check("halt F1", 32'(h_v), 32'(E_PCI));
                2:       check("halt F2", 32'(h_v), 32'(E_IRL));
                default: check($sformatf("halt idle %0d", i), 32'(h_v), 32'h0);
            endcase
        end
        #1;
        reset = 1'b0;
        #1;
        check("halt left by reset", 32'(h_v), 32'(E_F0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
